sm4_round_key_store: RTL and testbench

//  Runs the SM4 key schedule for one 128-bit master key and stores all 32 round keys.

---
 rtl/sm4_round_key_store.sv | 142 ++++++++++++++
 tb/tb_sm4_round_key_store.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sm4_round_key_store.sv
// SM4 key schedule: expands one 128-bit master key into 32 round keys and serves
// them through a round-indexed read port in forward or reversed order.

module transform_for_key_exp (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  logic [31:0] b;

  always_comb begin
    b    = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};
    // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
    dout = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  end
endmodule

module sm4_round_key_store #(
  parameter int ROUNDS = 32,
  parameter bit RD_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic         decrypt,
  input  logic [4:0]   rd_round,
  output logic         busy,
  output logic         key_ready,
  output logic [31:0]  rd_key
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  state_e       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [127:0] win_q, win_d;
  logic [31:0]  rk_q [ROUNDS];
  logic         rk_we;
  logic [7:0]   ck_base;
  logic [31:0]  ck, t_in, t_out, new_k;
  logic [4:0]   idx;
  logic [31:0]  rd_key_d;

  // CK byte j of round i is (4i+j)*7 mod 256, MSB first
  always_comb begin
    ck_base = {1'b0, cnt_q, 2'b00};
    ck      = {ck_base * 8'd7, (ck_base + 8'd1) * 8'd7,
               (ck_base + 8'd2) * 8'd7, (ck_base + 8'd3) * 8'd7};
    t_in    = win_q[95:64] ^ win_q[63:32] ^ win_q[31:0] ^ ck;
    new_k   = win_q[127:96] ^ t_out;
  end

  transform_for_key_exp u_tp (
    .din  (t_in),
    .dout (t_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    rk_we   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (key_load) begin
          win_d   = key_in ^ FK;
          cnt_d   = '0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (key_load) begin
          win_d   = key_in ^ FK;
          cnt_d   = '0;
        end else begin
          rk_we = 1'b1;
          win_d = {win_q[95:0], new_k};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(ROUNDS - 1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROUNDS; i++) rk_q[i] <= '0;
    end else if (rk_we) begin
      rk_q[cnt_q] <= new_k;
    end
  end

  assign busy      = (state_q == EXPAND);
  assign key_ready = (state_q == DONE);

  always_comb begin
    idx      = decrypt ? (5'd31 - rd_round) : rd_round;
    rd_key_d = key_ready ? rk_q[idx] : '0;
  end

  generate
    if (RD_REG) begin : g_rd_reg
      logic [31:0] rd_key_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_key_q <= '0;
        else        rd_key_q <= rd_key_d;
      end
      assign rd_key = rd_key_q;
    end else begin : g_rd_comb
      assign rd_key = rd_key_d;
    end
  endgenerate
endmodule

// File: tb/tb_sm4_round_key_store.sv
// Bench for sm4_round_key_store: directed sequence with random keys and reads,
// checked against a word-list model of the SM4 key schedule.

module tb_sm4_round_key_store;
  localparam logic [127:0] VEC_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [31:0]  FKW [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
  localparam logic [2047:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_load = 1'b0;
  logic         decrypt = 1'b0;
  logic [4:0]   rd_round = '0;
  logic         busy, key_ready;
  logic [31:0]  rd_key;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ref_rk [32];

  sm4_round_key_store dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_load  (key_load),
    .decrypt   (decrypt),
    .rd_round  (rd_round),
    .busy      (busy),
    .key_ready (key_ready),
    .rd_key    (rd_key)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no summary, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] t_prime(input logic [31:0] x);
    logic [31:0] b;
    for (int j = 0; j < 4; j++) begin
      int v;
      v = int'(x[8*j +: 8]);
      b[8*j +: 8] = SB[2047 - 8*v -: 8];
    end
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  task automatic model(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] ck;
    for (int i = 0; i < 4; i++) k[i] = mk[127 - 32*i -: 32] ^ FKW[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      k[i+4] = k[i] ^ t_prime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      ref_rk[i] = k[i+4];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    model(k);
  endtask

  // called right after load(); counts busy cycles starting with the load edge
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (n > 0) chk({tag, "_rd_zero"}, rd_key, 32'h0);
      rd_round = 5'($urandom_range(0, 31));
      decrypt  = 1'($urandom_range(0, 1));
      n++;
      step();
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'd32);
    chk({tag, "_key_ready"}, {31'b0, key_ready}, 32'd1);
  endtask

  task automatic rd(input string tag, input int r, input bit d, input logic [31:0] exp);
    rd_round = 5'(r);
    decrypt  = d;
    step();
    chk(tag, rd_key, exp);
  endtask

  task automatic sweep(input string tag);
    for (int r = 0; r < 32; r++) rd({tag, "_fwd"}, r, 1'b0, ref_rk[r]);
    for (int r = 0; r < 32; r++) rd({tag, "_dec"}, r, 1'b1, ref_rk[31 - r]);
  endtask

  initial begin
    logic [127:0] rk_a;
    int r;
    bit d;

    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, key_ready}, 32'd0);
    chk("rst_rd_key", rd_key, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    rd("idle_rd", 7, 1'b0, 32'h0);

    // standard vector, forward and reversed reads
    load(VEC_KEY);
    wait_ready("vec");
    rd("vec_rk0", 0, 1'b0, 32'hF12186F9);
    rd("vec_rk31", 31, 1'b0, 32'h9124A012);
    rd("vec_dec0", 0, 1'b1, 32'h9124A012);
    rd("vec_dec31", 31, 1'b1, 32'hF12186F9);
    sweep("vec");

    // random key, random read pattern with decrypt toggling every cycle
    load({$urandom, $urandom, $urandom, $urandom});
    wait_ready("rnd");
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 31);
      d = 1'($urandom_range(0, 1));
      rd("rnd_read", r, d, d ? ref_rk[31 - r] : ref_rk[r]);
    end

    // abort: second load after 10 cycles of expansion restarts
    rk_a = {$urandom, $urandom, $urandom, $urandom};
    load(rk_a);
    for (int i = 0; i < 9; i++) begin
      chk("abort_busy_hold", {31'b0, busy}, 32'd1);
      step();
    end
    load(VEC_KEY);
    wait_ready("abort");
    rd("abort_rk0", 0, 1'b0, 32'hF12186F9);
    sweep("abort");

    // async reset in the middle of expansion
    load({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 14; i++) step();
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_ready", {31'b0, key_ready}, 32'd0);
    chk("async_rst_rd_key", rd_key, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    load({$urandom, $urandom, $urandom, $urandom});
    wait_ready("post_rst");
    sweep("post_rst");

    // reload from DONE with the all-zero key
    rd_round = 5'd3;
    decrypt  = 1'b0;
    load(128'h0);
    chk("reload_ready_drop", {31'b0, key_ready}, 32'd0);
    chk("reload_busy", {31'b0, busy}, 32'd1);
    wait_ready("zero");
    rd("zero_rk0", 0, 1'b0, ref_rk[0]);
    sweep("zero");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
